spi_burst_master: RTL and testbench

- Next-generation SPI master engine for the SPI I/F block family.
- Replaces the single-byte, register-at-a-time transfer with buffered multi-byte bursts, selectable SPI mode (CPOL/CPHA) and N chip selects.
- Sits between the SPI CSR bank (which supplies control fields and FIFO push/pop strobes) and the external SPI pads.
- Raises a completion interrupt when a burst ends.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_sync_fifo.sv | 39 +++
 rtl/spi_burst_master.sv | 128 ++++++++++++
 tb/tb_spi_burst_master.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, constants and helpers for the SPI burst master.
package spi_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, HOLD} spiState_t;
    localparam int lpDivClk = 16;
    localparam int lpByteW = 8;
    localparam int lpEdgesPerByte = 2 * lpByteW;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: byte-wide first-word fall-through FIFO with full/empty/level.
module spi_sync_fifo import spi_pkg::*; #(
    parameter int pDepth = 16,
    localparam int lpAw = clog2(pDepth)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [lpByteW-1:0] wd,
    input  logic               we,
    input  logic               re,
    output logic [lpByteW-1:0] rd,
    output logic               full,
    output logic               empty,
    output logic [lpAw:0]      level
);
    logic [lpByteW-1:0] mem [pDepth];
    logic [lpAw-1:0] wrPtr, rdPtr;
    logic doPush, doPop;
    assign empty = level == '0;
    assign full = level == (lpAw + 1)'(pDepth);
    // a push and pop together always both proceed, so the level holds even at full or empty
    assign doPush = we && (!full || re);
    assign doPop = re && (!empty || we);
    assign rd = mem[rdPtr];
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= wd;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            wrPtr <= doPush ? wrPtr + lpAw'(1) : wrPtr;
            rdPtr <= doPop ? rdPtr + lpAw'(1) : rdPtr;
            level <= level + (lpAw + 1)'(doPush) - (lpAw + 1)'(doPop);
        end
    end
endmodule

// File: rtl/spi_burst_master.sv
// spi_burst_master: buffered multi-byte SPI master with selectable mode and chip select.
module spi_burst_master import spi_pkg::*; #(
    parameter int pDivClk = lpDivClk,
    parameter int pCsNum = 2,
    parameter int pFifoDepth = 16,
    parameter int pLenWidth = 16,
    localparam int lpSelW = clog2(pCsNum) > 1 ? clog2(pCsNum) : 1,
    localparam int lpLvlW = clog2(pFifoDepth) + 1
) (
    input  logic                 iSCLK,
    input  logic                 iSRST,
    input  logic                 iSPIEn,
    input  logic [pDivClk-1:0]   iSPIDiv,
    input  logic                 iCpol,
    input  logic                 iCpha,
    input  logic [lpSelW-1:0]    iCsSel,
    input  logic [pLenWidth-1:0] iBurstLen,
    input  logic                 iStart,
    input  logic [lpByteW-1:0]   iTxWd,
    input  logic                 iTxWe,
    output logic                 oTxFull,
    output logic [lpByteW-1:0]   oRxRd,
    input  logic                 iRxRe,
    output logic                 oRxEmpty,
    output logic [lpLvlW-1:0]    oRxLevel,
    output logic                 oBusy,
    output logic                 oMSpiIntr,
    output logic                 oSpiSck,
    output logic                 oSpiMosi,
    input  logic                 iSpiMiso,
    output logic [pCsNum-1:0]    oSpiCs
);
    spiState_t state;
    logic cpolL, cphaL, sck, mosi, busy, intr, tick, txPop, rxPush, txEmpty, rxFull;
    logic [pDivClk-1:0] divL, divCnt;
    logic [pLenWidth-1:0] lenRem;
    logic [3:0] edgeCnt;
    logic [lpByteW-1:0] sh, rxSh, txRd, rxWd;
    logic [pCsNum-1:0] csN;
    logic [lpLvlW-1:0] txLevelUnused;

    assign tick = divCnt == divL;
    assign txPop = iSPIEn && state == LOAD && !txEmpty && !rxFull;
    assign rxPush = iSPIEn && state == SHIFT && tick && edgeCnt == 4'(lpEdgesPerByte - 1);
    // with CPHA=1 the last edge of the byte is itself a sample
    assign rxWd = cphaL ? {rxSh[lpByteW-2:0], iSpiMiso} : rxSh;
    assign {oSpiSck, oSpiMosi, oSpiCs, oBusy, oMSpiIntr} = {sck, mosi, csN, busy, intr};

    spi_sync_fifo #(.pDepth(pFifoDepth)) txFifo (
        .clk(iSCLK), .rst(iSRST), .wd(iTxWd), .we(iTxWe), .re(txPop),
        .rd(txRd), .full(oTxFull), .empty(txEmpty), .level(txLevelUnused)
    );
    spi_sync_fifo #(.pDepth(pFifoDepth)) rxFifo (
        .clk(iSCLK), .rst(iSRST), .wd(rxWd), .we(rxPush), .re(iRxRe),
        .rd(oRxRd), .full(rxFull), .empty(oRxEmpty), .level(oRxLevel)
    );

    always_ff @(posedge iSCLK) begin
        if (iSRST) begin
            state <= IDLE;
            cpolL <= 1'b0;
            cphaL <= 1'b0;
            divL <= '0;
            divCnt <= '0;
            lenRem <= '0;
            edgeCnt <= '0;
            sh <= '0;
            rxSh <= '0;
            sck <= 1'b0;
            mosi <= 1'b0;
            csN <= '1;
            busy <= 1'b0;
            intr <= 1'b0;
        end else begin
            intr <= 1'b0;
            divCnt <= (state == IDLE || state == LOAD || tick) ? '0 : divCnt + pDivClk'(1);
            if (state != IDLE && !iSPIEn) begin
                state <= IDLE;
                csN <= '1;
                sck <= cpolL;
                busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        sck <= iCpol;
                        if (iStart && iSPIEn && iBurstLen != '0) begin
                            cpolL <= iCpol;
                            cphaL <= iCpha;
                            divL <= iSPIDiv;
                            lenRem <= iBurstLen;
                            csN <= ~(pCsNum'(1) << iCsSel);
                            busy <= 1'b1;
                            state <= SETUP;
                        end
                    end
                    SETUP: if (tick) state <= LOAD;
                    LOAD: if (txPop) begin
                        // CPHA=0 presents bit 7 now; CPHA=1 drives it on the first leading edge
                        sh <= cphaL ? txRd : {txRd[lpByteW-2:0], 1'b0};
                        mosi <= cphaL ? mosi : txRd[lpByteW-1];
                        edgeCnt <= '0;
                        state <= SHIFT;
                    end
                    SHIFT: if (tick) begin
                        sck <= ~sck;
                        edgeCnt <= edgeCnt + 4'd1;
                        if (edgeCnt[0] == cphaL) rxSh <= {rxSh[lpByteW-2:0], iSpiMiso};
                        else begin
                            mosi <= sh[lpByteW-1];
                            sh <= {sh[lpByteW-2:0], 1'b0};
                        end
                        if (rxPush) begin
                            lenRem <= lenRem - pLenWidth'(1);
                            state <= lenRem == pLenWidth'(1) ? HOLD : LOAD;
                        end
                    end
                    HOLD: if (tick) begin
                        csN <= '1;
                        busy <= 1'b0;
                        intr <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_burst_master.sv
// tb_spi_burst_master: directed vectors and multi-cycle corner sequences for spi_burst_master.
`timescale 1ns/1ps
module tb_spi_burst_master;
    localparam int lpDepth = 4;
    typedef struct packed {
        logic        cpol;
        logic        cpha;
        logic [15:0] div;
        logic        cs;
        logic [15:0] len;
        logic [31:0] tx;
        logic        loop;
        logic [7:0]  pat;
        logic [31:0] exp;
        logic [1:0]  expCs;
    } vec_t;

    logic clk = 1'b0, rst, spiEn, cpol, cpha, csSel, start, txWe, rxRe, miso, loop;
    logic txFull, rxEmpty, busy, intr, sck, mosi, prevSck = 1'b0, prevMosi = 1'b0;
    logic [15:0] div, burstLen;
    logic [7:0] txWd, rxRd, pat;
    logic [2:0] rxLevel;
    logic [1:0] cs, expCs;
    int total = 0, bad = 0, shiftCnt = 0, riseCnt = 0, intrCnt = 0, csBad = 0, mosiBad = 0;
    vec_t vecs [4];

    always #5 clk = ~clk;

    spi_burst_master #(.pDivClk(16), .pCsNum(2), .pFifoDepth(lpDepth), .pLenWidth(16)) dut (
        .iSCLK(clk), .iSRST(rst), .iSPIEn(spiEn), .iSPIDiv(div), .iCpol(cpol), .iCpha(cpha),
        .iCsSel(csSel), .iBurstLen(burstLen), .iStart(start), .iTxWd(txWd), .iTxWe(txWe),
        .oTxFull(txFull), .oRxRd(rxRd), .iRxRe(rxRe), .oRxEmpty(rxEmpty), .oRxLevel(rxLevel),
        .oBusy(busy), .oMSpiIntr(intr), .oSpiSck(sck), .oSpiMosi(mosi), .iSpiMiso(miso), .oSpiCs(cs)
    );

    // slave model: loopback, or a fixed byte pattern advanced on each shift edge
    assign miso = loop ? mosi : pat[7 - ((shiftCnt + 8 - int'(cpha)) % 8)];

    always @(negedge clk) begin
        if (busy && cs !== expCs) csBad++;
        if (busy && cpha && mosi !== prevMosi && !(sck !== prevSck && sck !== cpol)) mosiBad++;
        if (sck !== prevSck && sck === 1'b1) riseCnt++;
        if (intr) intrCnt++;
        if (!busy) shiftCnt = 0;
        else if (sck !== prevSck && ((sck !== cpol) == cpha)) shiftCnt++;
        prevSck = sck;
        prevMosi = mosi;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        txWe = 1'b1;
        txWd = d;
        @(negedge clk);
        txWe = 1'b0;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic popCheck(input string nm, input logic [7:0] exp);
        @(negedge clk);
        check(nm, rxRd, exp);
        rxRe = 1'b1;
        @(negedge clk);
        rxRe = 1'b0;
    endtask

    task automatic waitIdle(input string nm);
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({nm, " idle"}, busy, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic waitLevel(input int lvl, input string nm);
        int n = 0;
        while (int'(rxLevel) != lvl && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(nm, rxLevel, lvl);
    endtask

    task automatic waitNotFull(input string nm);
        int n = 0;
        while (txFull && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(nm, txFull, 1'b0);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int r0, i0, c0, m0, flag;
        vecs[0] = '{1'b0, 1'b0, 16'd1, 1'b0, 16'd2, 32'hA53C_0000, 1'b1, 8'h00, 32'hA53C_0000, 2'b10};
        vecs[1] = '{1'b1, 1'b1, 16'd1, 1'b1, 16'd1, 32'h8100_0000, 1'b0, 8'h5A, 32'h5A00_0000, 2'b01};
        vecs[2] = '{1'b0, 1'b1, 16'd0, 1'b0, 16'd3, 32'h1234_5600, 1'b1, 8'h00, 32'h1234_5600, 2'b10};
        vecs[3] = '{1'b1, 1'b0, 16'd2, 1'b1, 16'd2, 32'hF00F_0000, 1'b0, 8'hC3, 32'hC3C3_0000, 2'b01};
        rst = 1'b1; spiEn = 1'b1; cpol = 1'b1; cpha = 1'b0; div = 16'd0; csSel = 1'b0;
        burstLen = 16'd0; start = 1'b0; txWe = 1'b0; txWd = 8'h00; rxRe = 1'b0;
        loop = 1'b1; pat = 8'h00; expCs = 2'b11;
        repeat (3) @(negedge clk);
        check("reset cs", cs, 2'b11);
        check("reset sck", sck, 1'b0);
        check("reset mosi", mosi, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset intr", intr, 1'b0);
        check("reset txfull", txFull, 1'b0);
        check("reset rxempty", rxEmpty, 1'b1);
        check("reset rxlevel", rxLevel, 3'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle sck follows cpol", sck, 1'b1);

        for (int i = 0; i < 4; i++) begin
            v = vecs[i];
            @(negedge clk);
            cpol = v.cpol; cpha = v.cpha; div = v.div; csSel = v.cs; burstLen = v.len;
            loop = v.loop; pat = v.pat; expCs = v.expCs;
            for (int j = 0; j < int'(v.len); j++) push(v.tx[31-8*j -: 8]);
            check($sformatf("vec%0d idle sck", i), sck, v.cpol);
            r0 = riseCnt; i0 = intrCnt; c0 = csBad; m0 = mosiBad;
            pulseStart();
            waitIdle($sformatf("vec%0d", i));
            check($sformatf("vec%0d sck rises", i), riseCnt - r0, 8 * int'(v.len));
            check($sformatf("vec%0d intr pulses", i), intrCnt - i0, 1);
            check($sformatf("vec%0d cs during burst", i), csBad - c0, 0);
            check($sformatf("vec%0d mosi edge", i), mosiBad - m0, 0);
            check($sformatf("vec%0d cs after", i), cs, 2'b11);
            for (int j = 0; j < int'(v.len); j++) popCheck($sformatf("vec%0d rx%0d", i, j), v.exp[31-8*j -: 8]);
            check($sformatf("vec%0d rx drained", i), rxEmpty, 1'b1);
        end

        // TX starvation: stall with CS low and SCK idle until more bytes arrive
        cpol = 1'b0; cpha = 1'b0; div = 16'd0; csSel = 1'b0; loop = 1'b1; expCs = 2'b10; burstLen = 16'd3;
        push(8'hC1);
        i0 = intrCnt; c0 = csBad;
        pulseStart();
        waitLevel(1, "starve first byte");
        r0 = riseCnt;
        repeat (20) @(negedge clk);
        check("starve no sck", riseCnt - r0, 0);
        check("starve busy", busy, 1'b1);
        check("starve cs low", cs, 2'b10);
        check("starve sck idle", sck, 1'b0);
        push(8'hC2);
        push(8'hC3);
        waitIdle("starve");
        check("starve rx level", rxLevel, 3'd3);
        check("starve intr", intrCnt - i0, 1);
        check("starve cs", csBad - c0, 0);
        popCheck("starve rx0", 8'hC1);
        popCheck("starve rx1", 8'hC2);
        popCheck("starve rx2", 8'hC3);

        // RX backpressure with a full TX push dropped first
        csSel = 1'b1; expCs = 2'b01; burstLen = 16'd6;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        check("tx full", txFull, 1'b1);
        push(8'hEE);
        i0 = intrCnt;
        pulseStart();
        waitNotFull("bp room 5");
        push(8'h55);
        waitNotFull("bp room 6");
        push(8'h66);
        waitLevel(4, "bp rx full");
        r0 = riseCnt;
        repeat (20) @(negedge clk);
        check("bp stalled busy", busy, 1'b1);
        check("bp stalled level", rxLevel, 3'd4);
        check("bp stalled sck", riseCnt - r0, 0);
        popCheck("bp rx0", 8'h11);
        popCheck("bp rx1", 8'h22);
        waitIdle("bp");
        check("bp rx level", rxLevel, 3'd4);
        check("bp intr", intrCnt - i0, 1);
        popCheck("bp rx2", 8'h33);
        popCheck("bp rx3", 8'h44);
        popCheck("bp rx4", 8'h55);
        popCheck("bp rx5", 8'h66);

        // abort mid byte 2, then drain the retained TX bytes
        div = 16'd1; csSel = 1'b0; expCs = 2'b10; burstLen = 16'd4;
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        i0 = intrCnt;
        pulseStart();
        waitLevel(1, "abort first byte");
        repeat (6) @(negedge clk);
        spiEn = 1'b0;
        @(negedge clk);
        check("abort cs", cs, 2'b11);
        check("abort busy", busy, 1'b0);
        check("abort sck", sck, 1'b0);
        repeat (5) @(negedge clk);
        check("abort no intr", intrCnt - i0, 0);
        check("abort rx level", rxLevel, 3'd1);
        spiEn = 1'b1;
        popCheck("abort rx0", 8'hA1);
        burstLen = 16'd2;
        pulseStart();
        waitIdle("abort drain");
        popCheck("abort drain0", 8'hA3);
        popCheck("abort drain1", 8'hA4);

        // zero-length start is ignored; a start while busy does not disturb the burst
        burstLen = 16'd0; i0 = intrCnt; flag = 0;
        pulseStart();
        repeat (10) begin
            @(negedge clk);
            if (busy || cs !== 2'b11) flag++;
        end
        check("len0 no activity", flag, 0);
        check("len0 no intr", intrCnt - i0, 0);
        push(8'h96); push(8'h69);
        burstLen = 16'd2; expCs = 2'b10; csSel = 1'b0;
        i0 = intrCnt; c0 = csBad; r0 = riseCnt;
        pulseStart();
        repeat (10) @(negedge clk);
        csSel = 1'b1; burstLen = 16'd1;
        pulseStart();
        waitIdle("restart");
        check("restart intr", intrCnt - i0, 1);
        check("restart cs", csBad - c0, 0);
        check("restart sck rises", riseCnt - r0, 16);
        check("restart rx level", rxLevel, 3'd2);
        popCheck("restart rx0", 8'h96);
        popCheck("restart rx1", 8'h69);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
